// File: rtl/memory_pkg.sv
// Shared sizing constants and types for the 32x32 scratch RAM.
// Optional byte-lane writes are enabled by the MEMORY_BYTE_WRITE_EN macro.
package memory_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 5;
  localparam int DEPTH          = 2 ** MEM_ADDR_WIDTH;
  localparam int BYTES          = MEM_DATA_WIDTH / 8;

  typedef logic [MEM_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/memory_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take din, others keep the old word.
// Instantiated by memory_32x32 only when MEMORY_BYTE_WRITE_EN is defined.
module memory_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   new_word
);

  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
    assign new_word[8*gi +: 8] = be[gi] ? din[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/memory_32x32.sv
// Single-port 32x32 register-file RAM with registered read and async clear.
// Define MEMORY_BYTE_WRITE_EN to add the per-byte write enable port be.
module memory_32x32
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cen,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
`ifdef MEMORY_BYTE_WRITE_EN
  input  logic [DATA_WIDTH/8-1:0] be,
`endif
  output logic [DATA_WIDTH-1:0]   dout
);

  localparam int WORDS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] mem_d [WORDS];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] wr_word;

`ifdef MEMORY_BYTE_WRITE_EN
  memory_byte_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_merge (
    .old_word(mem_q[addr]),
    .din     (din),
    .be      (be),
    .new_word(wr_word)
  );
`else
  assign wr_word = din;
`endif

  always_comb begin
    mem_d  = mem_q;
    dout_d = '0;
    if (cen && wen) begin
      mem_d[addr] = wr_word;
    end else if (cen) begin
      dout_d = mem_q[addr];
    end
  end

  // Register storage (not inferred RAM) so the whole array clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_memory_32x32.sv
// Directed self-checking bench for memory_32x32 (byte-lane case under MEMORY_BYTE_WRITE_EN).
module tb_memory_32x32;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic [31:0] dout;

  int checks   = 0;
  int failures = 0;

  memory_32x32 dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cen    (cen),
    .wen    (wen),
    .addr   (addr),
    .din    (din),
`ifdef MEMORY_BYTE_WRITE_EN
    .be     (be),
`endif
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=%08h", tag, got);
    end
  endtask

  // Apply one access, wait for the sampling edge, return 1 time unit after it.
  task automatic access(input logic c, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    cen  = c;
    wen  = w;
    addr = a;
    din  = d;
    be   = b;
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  wa [4] = '{5'd1, 5'd2, 5'd3, 5'd10};
  logic [31:0] exp_v;

  initial begin
    reset_n = 1'b0;
    cen = 1'b1; wen = 1'b0; addr = 5'd7; din = '0; be = 4'hF;
    #2;
    check_eq("reset_dout_async", dout, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("reset_dout_held", dout, 32'h0);
    reset_n = 1'b1;
    access(1'b1, 1'b0, 5'd7, 32'h0, 4'hF);
    check_eq("read7_after_reset", dout, 32'h0);

    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b1, wa[i], {27'd0, wa[i]}, 4'hF);
      check_eq($sformatf("write_dout_a%0d", wa[i]), dout, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, wa[i], 32'h0, 4'hF);
      exp_v = {27'd0, wa[i]};
      check_eq($sformatf("read_a%0d", wa[i]), dout, exp_v);
    end

    access(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    check_eq("write5_dout", dout, 32'h0);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, 5'd5, 32'h0, 4'hF);
      check_eq($sformatf("cen0_dout_%0d", i), dout, 32'h0);
    end
    access(1'b1, 1'b0, 5'd5, 32'h0, 4'hF);
    check_eq("read5_after_cen0", dout, 32'hDEADBEEF);

    access(1'b1, 1'b1, 5'd0, 32'hA5A5A5A5, 4'hF);
    access(1'b1, 1'b0, 5'd0, 32'h0, 4'hF);
    check_eq("write_then_read0", dout, 32'hA5A5A5A5);

    access(1'b1, 1'b1, 5'd4, 32'hFFFFFFFF, 4'hF);
    access(1'b1, 1'b1, 5'd4, 32'h00000000, 4'b0101);
    access(1'b1, 1'b0, 5'd4, 32'h0, 4'b0000);
`ifdef MEMORY_BYTE_WRITE_EN
    check_eq("byte_merge_a4", dout, 32'hFF00FF00);
`else
    check_eq("full_write_a4", dout, 32'h00000000);
`endif

    access(1'b1, 1'b1, 5'd31, 32'h12345678, 4'hF);
    access(1'b1, 1'b0, 5'd31, 32'h0, 4'hF);
    check_eq("read31_before_reset", dout, 32'h12345678);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("midreset_dout_async", dout, 32'h0);
    #2;
    reset_n = 1'b1;
    access(1'b1, 1'b0, 5'd31, 32'h0, 4'hF);
    check_eq("read31_after_reset", dout, 32'h0);
    access(1'b1, 1'b0, 5'd5, 32'h0, 4'hF);
    check_eq("read5_after_reset", dout, 32'h0);
    access(1'b1, 1'b0, 5'd10, 32'h0, 4'hF);
    check_eq("read10_after_reset", dout, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
